// File: rtl/md5_hex_sender.sv
// md5_hex_sender: prints one digest as ASCII hex (optionally followed by CR LF) through a start/busy UART transmitter.
module md5_hex_sender #(
  parameter int DIGEST_BITS = 128,
  parameter int SEND_CRLF   = 1,
  parameter int UPPERCASE   = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   digest_valid,
  input  logic [DIGEST_BITS-1:0] digest,
  output logic                   digest_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy
);
  localparam int NH  = DIGEST_BITS / 4;
  localparam int NCH = NH + 2 * SEND_CRLF;
  localparam int CW  = $clog2(NCH + 1);
  typedef enum logic [1:0] {IDLE, START, ACK, DRAIN} state_t;
  state_t                 state, state_n;
  logic [DIGEST_BITS-1:0] sh, sh_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [7:0]             tx_data_n;
  logic                   tx_start_n, busy_n, done_n;
  function automatic logic [7:0] hex(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'h0, n} : (UPPERCASE != 0 ? 8'h37 : 8'h57) + {4'h0, n};
  endfunction
  function automatic logic [7:0] char_at(input logic [CW-1:0] idx, input logic [DIGEST_BITS-1:0] v);
    return idx < CW'(NH) ? hex(v[DIGEST_BITS-1 -: 4]) : idx == CW'(NH) ? 8'h0d : 8'h0a;
  endfunction
  // the done cycle is excluded so a digest held across it is taken one cycle later
  assign digest_ready = state == IDLE && !done;
  always_comb begin
    state_n    = state;
    sh_n       = sh;
    cnt_n      = cnt;
    tx_data_n  = tx_data;
    tx_start_n = tx_start;
    busy_n     = busy;
    done_n     = 1'b0;
    case (state)
      IDLE:
        if (digest_valid && !done) begin
          sh_n      = digest;
          cnt_n     = '0;
          tx_data_n = hex(digest[DIGEST_BITS-1 -: 4]);
          busy_n    = 1'b1;
          state_n   = START;
        end
      START:
        if (!tx_busy) begin
          tx_start_n = 1'b1;
          state_n    = ACK;
        end
      ACK: begin
        tx_start_n = 1'b0;
        state_n    = tx_busy ? DRAIN : ACK;
      end
      DRAIN:
        if (!tx_busy) begin
          if (cnt == CW'(NCH - 1)) begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
          end else begin
            cnt_n     = cnt + 1'b1;
            sh_n      = sh << 4;
            tx_data_n = char_at(cnt_n, sh_n);
            state_n   = START;
          end
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sh       <= '0;
      cnt      <= '0;
      tx_data  <= 8'h00;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      sh       <= sh_n;
      cnt      <= cnt_n;
      tx_data  <= tx_data_n;
      tx_start <= tx_start_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end
endmodule

// File: tb/tb_md5_hex_sender.sv
// tb_md5_hex_sender: three parameterisations driven against a bus-functional UART and a reference byte-stream model.
module tb_md5_hex_sender;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [127:0] dg0 = '0, dg1 = '0;
  logic [7:0]   dg2 = '0;
  logic [2:0]   valid = '0, ready, busy, done, start, tbusy;
  logic [2:0]   u_busy = '0, hold = '0, pstart = '0, pdone = '0;
  logic [7:0]   data [3];
  logic [7:0]   lat [3];
  int           ucnt [3];
  logic [7:0]   rx [3][1024];
  int           rx_n [3], done_cnt [3], wide [3], dwide [3], sib [3], unstable [3];
  logic [7:0]   expq [64];
  int           exp_n;
  int           checks = 0, passes = 0;
  assign tbusy = u_busy | hold;

  md5_hex_sender dut0 (.clk(clk), .rst_n(rst_n), .digest_valid(valid[0]), .digest(dg0), .digest_ready(ready[0]),
    .busy(busy[0]), .done(done[0]), .tx_start(start[0]), .tx_data(data[0]), .tx_busy(tbusy[0]));
  md5_hex_sender #(.UPPERCASE(1)) dut1 (.clk(clk), .rst_n(rst_n), .digest_valid(valid[1]), .digest(dg1),
    .digest_ready(ready[1]), .busy(busy[1]), .done(done[1]), .tx_start(start[1]), .tx_data(data[1]), .tx_busy(tbusy[1]));
  md5_hex_sender #(.DIGEST_BITS(8), .SEND_CRLF(0)) dut2 (.clk(clk), .rst_n(rst_n), .digest_valid(valid[2]), .digest(dg2),
    .digest_ready(ready[2]), .busy(busy[2]), .done(done[2]), .tx_start(start[2]), .tx_data(data[2]), .tx_busy(tbusy[2]));

  // UART model: busy rises the cycle after start is seen and lasts a random number of cycles
  initial for (int g = 0; g < 3; g++) begin
    rx_n[g] = 0; done_cnt[g] = 0; wide[g] = 0; dwide[g] = 0; sib[g] = 0; unstable[g] = 0; ucnt[g] = 0; lat[g] = '0;
  end
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (start[g] && pstart[g]) wide[g] <= wide[g] + 1;
      if (done[g] && pdone[g]) dwide[g] <= dwide[g] + 1;
      if (done[g]) done_cnt[g] <= done_cnt[g] + 1;
      if (start[g] && tbusy[g]) sib[g] <= sib[g] + 1;
      if (!rst_n) u_busy[g] <= 1'b0;
      else if (u_busy[g]) begin
        if (data[g] !== lat[g]) unstable[g] <= unstable[g] + 1;
        if (ucnt[g] == 0) u_busy[g] <= 1'b0;
        else ucnt[g] <= ucnt[g] - 1;
      end else if (start[g]) begin
        u_busy[g] <= 1'b1;
        lat[g]    <= data[g];
        ucnt[g]   <= int'($urandom_range(1, 6));
        if (rx_n[g] < 1024) rx[g][rx_n[g]] <= data[g];
        rx_n[g] <= rx_n[g] + 1;
      end
    end
    pstart <= start;
    pdone  <= done;
  end

  task automatic build_exp(input logic [127:0] d, input int nib, input bit crlf, input bit upper);
    exp_n = 0;
    for (int i = nib - 1; i >= 0; i--) begin
      int n;
      n = int'((d >> (4 * i)) & 128'hf);
      expq[exp_n] = n < 10 ? 8'(48 + n) : 8'((upper ? 65 : 97) + n - 10);
      exp_n++;
    end
    if (crlf) begin
      expq[exp_n] = 8'h0d; expq[exp_n + 1] = 8'h0a; exp_n += 2;
    end
  endtask

  task automatic fill_str(input string s);
    exp_n = 0;
    for (int i = 0; i < s.len(); i++) begin expq[exp_n] = s[i]; exp_n++; end
    expq[exp_n] = 8'h0d; expq[exp_n + 1] = 8'h0a; exp_n += 2;
  endtask

  task automatic set_digest(input int g, input logic [127:0] d);
    if (g == 0) dg0 = d;
    else if (g == 1) dg1 = d;
    else dg2 = d[7:0];
  endtask

  task automatic offer(input int g, input logic [127:0] d);
    @(negedge clk);
    set_digest(g, d);
    valid[g] = 1'b1;
    @(negedge clk);
    valid[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int d0, input string name);
    int t = 0;
    while (done_cnt[g] == d0 && t < 4000) begin @(negedge clk); t++; end
    checks++;
    if (done_cnt[g] == d0) $display("FAIL %s done_timeout: no done pulse after %0d cycles, required one", name, t);
    else passes++;
  endtask

  task automatic wait_rx(input int g, input int n, input string name);
    int t = 0;
    while (rx_n[g] < n && t < 2000) begin @(negedge clk); t++; end
    checks++;
    if (rx_n[g] < n) $display("FAIL %s rx_timeout: got %0d bytes, required %0d", name, rx_n[g], n);
    else passes++;
  endtask

  task automatic check_print(input int g, input int base, input string name);
    int bad = -1;
    checks++;
    if (rx_n[g] - base != exp_n) $display("FAIL %s count: got %0d bytes, required %0d", name, rx_n[g] - base, exp_n);
    else passes++;
    for (int i = 0; i < exp_n; i++) if (bad < 0 && rx[g][base + i] !== expq[i]) bad = i;
    checks++;
    if (bad >= 0) $display("FAIL %s byte%0d: got %02h, required %02h", name, bad, rx[g][base + bad], expq[bad]);
    else passes++;
  endtask

  task automatic do_print(input int g, input logic [127:0] d, input string name);
    int base = rx_n[g], d0 = done_cnt[g];
    offer(g, d);
    wait_done(g, d0, name);
    repeat (4) @(negedge clk);
    check_print(g, base, name);
    checks++;
    if (done_cnt[g] != d0 + 1) $display("FAIL %s done_pulses: got %0d, required 1", name, done_cnt[g] - d0);
    else passes++;
    checks++;
    if (busy[g] !== 1'b0) $display("FAIL %s busy_after: got %b, required 0", name, busy[g]);
    else passes++;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks += 5;
    if (busy[0] !== 1'b0) $display("FAIL reset busy: got %b, required 0", busy[0]); else passes++;
    if (done[0] !== 1'b0) $display("FAIL reset done: got %b, required 0", done[0]); else passes++;
    if (start[0] !== 1'b0) $display("FAIL reset tx_start: got %b, required 0", start[0]); else passes++;
    if (data[0] !== 8'h00) $display("FAIL reset tx_data: got %02h, required 00", data[0]); else passes++;
    if (ready[0] !== 1'b1) $display("FAIL reset ready: got %b, required 1", ready[0]); else passes++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_known;
    fill_str("0123456789abcdeffedcba9876543210");
    do_print(0, 128'h0123456789abcdeffedcba9876543210, "t1_lower");
    fill_str("D41D8CD98F00B204E9800998ECF8427E");
    do_print(1, 128'hd41d8cd98f00b204e9800998ecf8427e, "t2_upper");
    exp_n = 2; expq[0] = 8'h61; expq[1] = 8'h35;
    do_print(2, 128'ha5, "t3_short");
  endtask

  task automatic test_random;
    for (int k = 0; k < 4; k++) begin
      logic [127:0] d;
      d = {$urandom, $urandom, $urandom, $urandom};
      build_exp(d, 32, 1'b1, 1'b0); do_print(0, d, "rand_lower");
      build_exp(d, 32, 1'b1, 1'b1); do_print(1, d, "rand_upper");
      build_exp(d, 2, 1'b0, 1'b0);  do_print(2, d, "rand_short");
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] d, e;
    int base, d1, t;
    d = {$urandom, $urandom, $urandom, $urandom};
    e = ~d;
    build_exp(d, 32, 1'b1, 1'b0);
    base = rx_n[0];
    offer(0, d);
    wait_rx(0, base + 5, "t4_pulse");
    @(negedge clk); dg0 = e; valid[0] = 1'b1;
    @(negedge clk); valid[0] = 1'b0;
    d1 = done_cnt[0];
    wait_done(0, d1, "t4_pulse");
    repeat (4) @(negedge clk);
    check_print(0, base, "t4_pulse");
    base = rx_n[0];
    offer(0, d);
    wait_rx(0, base + 8, "t4_hold");
    @(negedge clk); dg0 = e; valid[0] = 1'b1;
    t = 0;
    while (done[0] !== 1'b1 && t < 4000) begin @(negedge clk); t++; end
    checks += 4;
    if (done[0] !== 1'b1) $display("FAIL t4_hold done_seen: got %b, required 1", done[0]); else passes++;
    if (ready[0] !== 1'b0) $display("FAIL t4_hold ready_in_done: got %b, required 0", ready[0]); else passes++;
    @(negedge clk);
    if (ready[0] !== 1'b1) $display("FAIL t4_hold ready_after_done: got %b, required 1", ready[0]); else passes++;
    @(negedge clk);
    if (busy[0] !== 1'b1) $display("FAIL t4_hold accepted: busy got %b, required 1", busy[0]); else passes++;
    valid[0] = 1'b0;
    check_print(0, base, "t4_hold_first");
    build_exp(e, 32, 1'b1, 1'b0);
    base = rx_n[0];
    d1 = done_cnt[0];
    wait_done(0, d1, "t4_hold_second");
    repeat (4) @(negedge clk);
    check_print(0, base, "t4_hold_second");
  endtask

  task automatic test_reset_mid;
    logic [127:0] d, e;
    int base, d0;
    d = {$urandom, $urandom, $urandom, $urandom};
    e = {$urandom, $urandom, $urandom, $urandom};
    base = rx_n[0];
    d0 = done_cnt[0];
    offer(0, d);
    wait_rx(0, base + 10, "t5");
    @(negedge clk);
    #2 rst_n = 1'b0; hold[0] = 1'b1;
    #1;
    checks += 2;
    if (start[0] !== 1'b0) $display("FAIL t5 reset tx_start: got %b, required 0", start[0]); else passes++;
    if (busy[0] !== 1'b0) $display("FAIL t5 reset busy: got %b, required 0", busy[0]); else passes++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    offer(0, e);
    base = rx_n[0];
    repeat (48) @(negedge clk);
    checks += 3;
    if (rx_n[0] != base) $display("FAIL t5 held_start: got %0d starts, required 0", rx_n[0] - base); else passes++;
    if (busy[0] !== 1'b1) $display("FAIL t5 held_busy: got %b, required 1", busy[0]); else passes++;
    if (done_cnt[0] != d0) $display("FAIL t5 abandoned_done: got %0d pulses, required 0", done_cnt[0] - d0); else passes++;
    hold[0] = 1'b0;
    build_exp(e, 32, 1'b1, 1'b0);
    wait_done(0, d0, "t5_after");
    repeat (4) @(negedge clk);
    check_print(0, base, "t5_after");
  endtask

  task automatic test_protocol;
    for (int g = 0; g < 3; g++) begin
      checks += 4;
      if (wide[g] != 0) $display("FAIL t6 inst%0d start_width: got %0d wide pulses, required 0", g, wide[g]); else passes++;
      if (sib[g] != 0) $display("FAIL t6 inst%0d start_while_busy: got %0d, required 0", g, sib[g]); else passes++;
      if (unstable[g] != 0) $display("FAIL t6 inst%0d data_stable: got %0d changes, required 0", g, unstable[g]); else passes++;
      if (dwide[g] != 0) $display("FAIL t6 inst%0d done_width: got %0d wide pulses, required 0", g, dwide[g]); else passes++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_known;
    test_random;
    test_back_to_back;
    test_reset_mid;
    test_protocol;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
